// File: rtl/ad9361_spi_engine.sv
// ad9361_spi_engine
// Serialises one AD9361 register command at a time into a 24-bit 4-wire SPI
// frame: {rw, 2'b00, 3'b000, addr[9:0], data[7:0]}, MSB first. A read returns
// the byte clocked in during bits 16..23 with a one-cycle rsp_valid pulse.
//
// Ports:
//   ACLK, ARESET           clock, synchronous active-high reset
//   cmd_valid/cmd_ready    command handshake (accept on valid && ready)
//   cmd_write/addr/wdata   command fields, sampled only on accept
//   rsp_valid, rsp_rdata   end-of-frame pulse and read byte (00 after a write)
//   busy                   ~cmd_ready
//   spi_csn/clk/mosi/miso  AD9361 SPI pins (clk idles low, mode 0 style)
module ad9361_spi_engine #(
  parameter int CLK_DIV = 4
) (
  input  logic       ACLK,
  input  logic       ARESET,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic [9:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic       spi_csn,
  output logic       spi_clk,
  output logic       spi_mosi,
  input  logic       spi_miso
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

  logic [2:0]  state;
  logic [7:0]  phase_cnt;
  logic [4:0]  bit_cnt;
  logic [23:0] sr;        // outgoing frame shifts out the top, miso shifts in the bottom
  logic        is_write;
  logic        phase_end;

  assign phase_end = (phase_cnt == 8'd0);
  assign busy      = ~cmd_ready;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= S_IDLE;
      phase_cnt <= 8'd0;
      bit_cnt   <= 5'd0;
      sr        <= 24'd0;
      is_write  <= 1'b0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      spi_csn   <= 1'b1;
      spi_clk   <= 1'b0;
      spi_mosi  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      // Every timed state lasts one full phase; the counter reloads whenever
      // the phase (or state) ends, so it needs no per-state handling.
      phase_cnt <= phase_end ? DIV_M1 : phase_cnt - 8'd1;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            sr        <= {cmd_write, 2'b00, 3'b000, cmd_addr,
                          cmd_write ? cmd_wdata : 8'h00};
            is_write  <= cmd_write;
            spi_mosi  <= cmd_write;  // frame bit 23 is presented during SETUP
            spi_csn   <= 1'b0;
            cmd_ready <= 1'b0;
            bit_cnt   <= 5'd0;
            phase_cnt <= DIV_M1;
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (phase_end) state <= S_SHIFT;  // enter low phase of bit 0
        end
        S_SHIFT: begin
          if (phase_end) begin
            if (!spi_clk) begin
              // Rising edge: sample miso on the same ACLK edge spi_clk rises.
              spi_clk <= 1'b1;
              sr      <= {sr[22:0], spi_miso};
            end else if (bit_cnt == 5'd23) begin
              spi_clk <= 1'b0;
              state   <= S_HOLD;
            end else begin
              // Falling edge: sr[23] already holds the next outgoing bit.
              spi_clk  <= 1'b0;
              spi_mosi <= sr[23];
              bit_cnt  <= bit_cnt + 5'd1;
            end
          end
        end
        S_HOLD: begin
          if (phase_end) begin
            spi_csn   <= 1'b1;
            spi_mosi  <= 1'b0;
            rsp_valid <= 1'b1;
            // The last eight samples (bits 16..23) sit in the low byte.
            rsp_rdata <= is_write ? 8'h00 : sr[7:0];
            state     <= S_GAP;
          end
        end
        S_GAP: begin
          if (phase_end) begin
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          cmd_ready <= 1'b1;
          spi_csn   <= 1'b1;
          spi_clk   <= 1'b0;
        end
      endcase
    end
  end

endmodule
